// File: rtl/chuchu_pkg.sv
// Shared sizes, FSM state type and page-age helper for the chuchu checkpoint manager.
package chuchu_pkg;

  localparam int unsigned NUM_PAGES = 8;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned CNT_W     = TAG_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } ckpt_state_t;

  // Distance of a page from the oldest page in circular allocation order.
  function automatic logic [TAG_W-1:0] page_age(input logic [TAG_W-1:0] page,
                                                input logic [TAG_W-1:0] head);
    return TAG_W'(page - head);
  endfunction

endpackage

// File: rtl/chuchu_ckpt_ctrl_if.sv
// Branch-unit and array-side signals of the checkpoint manager.
// Optional ckpt_err wire present when CHUCHU_CKPT_ERR_EN is defined.
interface chuchu_ckpt_ctrl_if;
  import chuchu_pkg::*;

  logic              alloc_req;
  logic              alloc_gnt;
  logic [TAG_W-1:0]  alloc_tag;
  logic              ckpt_full;
  logic              resolve_valid;
  logic [TAG_W-1:0]  resolve_tag;
  logic              resolve_mispr;
  logic              resolve_ready;
  logic              busy;
  logic              restore_done;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic [TAG_W-1:0]  shd_page;
  logic [ADDR_W-1:0] shd_addr;
  logic [DATA_W-1:0] shd_rdata;
  logic              shd_we;
  logic [DATA_W-1:0] shd_wdata;
`ifdef CHUCHU_CKPT_ERR_EN
  logic              ckpt_err;
`endif

  modport master (
    output alloc_req, resolve_valid, resolve_tag, resolve_mispr, arr_rdata, shd_rdata,
    input  alloc_gnt, alloc_tag, ckpt_full, resolve_ready, busy, restore_done,
           arr_addr, arr_we, arr_wdata, shd_page, shd_addr, shd_we, shd_wdata
`ifdef CHUCHU_CKPT_ERR_EN
         , ckpt_err
`endif
  );

  modport slave (
    input  alloc_req, resolve_valid, resolve_tag, resolve_mispr, arr_rdata, shd_rdata,
    output alloc_gnt, alloc_tag, ckpt_full, resolve_ready, busy, restore_done,
           arr_addr, arr_we, arr_wdata, shd_page, shd_addr, shd_we, shd_wdata
`ifdef CHUCHU_CKPT_ERR_EN
         , ckpt_err
`endif
  );

endinterface

// File: rtl/chuchu_ckpt_seq.sv
// Copy sequencer: entry index counter plus address/write muxing for save (dir=0)
// and restore (dir=1) copies between the live array and a shadow page.
module chuchu_ckpt_seq
  import chuchu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic              dir,
  input  logic [DATA_W-1:0] arr_rdata,
  input  logic [DATA_W-1:0] shd_rdata,
  output logic              last_c,
  output logic [ADDR_W-1:0] arr_addr_c,
  output logic [ADDR_W-1:0] shd_addr_c,
  output logic              arr_we_c,
  output logic              shd_we_c,
  output logic [DATA_W-1:0] arr_wdata_c,
  output logic [DATA_W-1:0] shd_wdata_c
);

  logic [ADDR_W-1:0] idx_q, idx_d;

  assign last_c = run && (idx_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  always_comb begin
    idx_d       = idx_q;
    arr_addr_c  = '0;
    shd_addr_c  = '0;
    arr_we_c    = 1'b0;
    shd_we_c    = 1'b0;
    arr_wdata_c = '0;
    shd_wdata_c = '0;
    if (start) begin
      idx_d = '0;
    end else if (run) begin
      idx_d = last_c ? '0 : ADDR_W'(idx_q + ADDR_W'(1));
    end
    if (run) begin
      arr_addr_c = idx_q;
      shd_addr_c = idx_q;
      if (dir) begin
        arr_we_c    = 1'b1;
        arr_wdata_c = shd_rdata;
      end else begin
        shd_we_c    = 1'b1;
        shd_wdata_c = arr_rdata;
      end
    end
  end

endmodule

// File: rtl/chuchu_ckpt_ctrl.sv
// Checkpoint manager: allocates shadow pages per branch, sequences save/restore
// copies and retires pages in age order. CHUCHU_CKPT_ERR_EN adds sticky ckpt_err.
module chuchu_ckpt_ctrl
  import chuchu_pkg::*;
(
  input logic               clk,
  input logic               reset,
  chuchu_ckpt_ctrl_if.slave bus
);

  ckpt_state_t          state_q, state_d;
  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d, page_q, page_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_PAGES-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic                 full, retire, mispr_req, tag_ok, gnt;
  logic                 seq_start, seq_run, seq_dir, seq_last;

  assign full      = (count_q == CNT_W'(NUM_PAGES));
  assign retire    = valid_q[head_q] & resolved_q[head_q];
  assign mispr_req = bus.resolve_valid & bus.resolve_mispr;
  assign tag_ok    = valid_q[bus.resolve_tag];
  assign seq_run   = (state_q == SAVE) || (state_q == RESTORE);
  assign seq_dir   = (state_q == RESTORE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      page_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      page_q     <= page_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    page_d     = page_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    gnt        = 1'b0;
    seq_start  = 1'b0;

    case (state_q)
      IDLE: begin
        // A mispredict blocks allocation even when its tag turns out invalid.
        if (mispr_req) begin
          if (tag_ok) begin
            state_d   = RESTORE;
            page_d    = bus.resolve_tag;
            seq_start = 1'b1;
          end
        end else begin
          if (bus.alloc_req && !full) begin
            gnt             = 1'b1;
            page_d          = tail_q;
            valid_d[tail_q] = 1'b1;
            tail_d          = TAG_W'(tail_q + TAG_W'(1));
            state_d         = SAVE;
            seq_start       = 1'b1;
          end
          if (bus.resolve_valid && tag_ok) resolved_d[bus.resolve_tag] = 1'b1;
        end
      end
      SAVE:    if (seq_last) state_d = IDLE;
      RESTORE: if (seq_last) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        tail_d  = page_q;
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = TAG_W'(head_q + TAG_W'(1));
    end
    count_d = CNT_W'(count_q + CNT_W'(gnt) - CNT_W'(retire));

    // Free the mispredicted page and everything allocated after it.
    if (state_q == DONE) begin
      count_d = CNT_W'(page_age(page_q, head_d));
      for (int unsigned p = 0; p < NUM_PAGES; p++) begin
        if (page_age(TAG_W'(p), head_q) >= page_age(page_q, head_q)) begin
          valid_d[p]    = 1'b0;
          resolved_d[p] = 1'b0;
        end
      end
    end
  end

  chuchu_ckpt_seq u_seq (
    .clk         (clk),
    .rst_n       (reset),
    .start       (seq_start),
    .run         (seq_run),
    .dir         (seq_dir),
    .arr_rdata   (bus.arr_rdata),
    .shd_rdata   (bus.shd_rdata),
    .last_c      (seq_last),
    .arr_addr_c  (bus.arr_addr),
    .shd_addr_c  (bus.shd_addr),
    .arr_we_c    (bus.arr_we),
    .shd_we_c    (bus.shd_we),
    .arr_wdata_c (bus.arr_wdata),
    .shd_wdata_c (bus.shd_wdata)
  );

  assign bus.alloc_gnt     = gnt;
  assign bus.alloc_tag     = gnt ? tail_q : '0;
  assign bus.ckpt_full     = full;
  assign bus.resolve_ready = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.restore_done  = (state_q == DONE);
  assign bus.shd_page      = seq_run ? page_q : '0;

`ifdef CHUCHU_CKPT_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.alloc_req & full)
                  | (bus.resolve_valid & (state_q == IDLE) & !tag_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.ckpt_err = err_q;
`endif

endmodule

// File: tb/tb_chuchu_ckpt_ctrl.sv
// Self-checking bench for chuchu_ckpt_ctrl with behavioural live/shadow memories.
module tb_chuchu_ckpt_ctrl;
  import chuchu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chuchu_ckpt_ctrl_if bus();
  chuchu_ckpt_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DATA_W-1:0] live [DEPTH];
  logic [DATA_W-1:0] shd  [NUM_PAGES][DEPTH];
  logic [DATA_W-1:0] snap [NUM_PAGES][DEPTH];
  logic [TAG_W-1:0]  exp_tags [$];

  int checks = 0;
  int errors = 0;
  logic             g;
  logic [TAG_W-1:0] t;
  logic [TAG_W-1:0] e;
  int               n;
  int               nwe;

  assign bus.arr_rdata = live[bus.arr_addr];
  assign bus.shd_rdata = shd[bus.shd_page][bus.shd_addr];

  always @(posedge clk) begin
    if (bus.arr_we) live[bus.arr_addr] <= bus.arr_wdata;
    if (bus.shd_we) shd[bus.shd_page][bus.shd_addr] <= bus.shd_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.alloc_req     = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_tag   = '0;
    bus.resolve_mispr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic randomize_live();
    for (int i = 0; i < DEPTH; i++) live[i] = DATA_W'($urandom);
  endtask

  task automatic take_snap(input int p);
    for (int i = 0; i < DEPTH; i++) snap[p][i] = live[i];
  endtask

  function automatic int page_diff(input int p);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (shd[p][i] !== snap[p][i]) bad++;
    return bad;
  endfunction

  function automatic int live_diff(input int p);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (live[i] !== snap[p][i]) bad++;
    return bad;
  endfunction

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic drive_alloc(output logic gnt, output logic [TAG_W-1:0] tag, output int cycles);
    @(negedge clk);
    bus.alloc_req = 1'b1;
    #1;
    gnt = bus.alloc_gnt;
    tag = bus.alloc_tag;
    @(negedge clk);
    bus.alloc_req = 1'b0;
    wait_idle(cycles);
  endtask

  task automatic wait_restore_done(output int we_cycles, output int cycles);
    we_cycles = 0;
    cycles    = 0;
    while (!bus.restore_done && cycles < 400) begin
      if (bus.arr_we) we_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.ckpt_full, bus.restore_done, bus.arr_we, bus.shd_we, bus.alloc_gnt} !== 6'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.busy, bus.ckpt_full, bus.restore_done, bus.arr_we, bus.shd_we, bus.alloc_gnt}); end
    checks++;
    if (bus.resolve_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.resolve_ready); end
    checks++;
    if ({bus.arr_addr, bus.shd_addr, bus.shd_page, bus.arr_wdata, bus.shd_wdata} !== 0)
      begin errors++; $display("FAIL reset_buses: got %h expected 0",
        {bus.arr_addr, bus.shd_addr, bus.shd_page, bus.arr_wdata, bus.shd_wdata}); end
`ifdef CHUCHU_CKPT_ERR_EN
    checks++;
    if (bus.ckpt_err !== 1'b0)
      begin errors++; $display("FAIL reset_err: got %b expected 0", bus.ckpt_err); end
`endif
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_save();
    randomize_live();
    take_snap(0);
    exp_tags.push_back(TAG_W'(0));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t} !== {1'b1, e})
      begin errors++; $display("FAIL save_grant: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    checks++;
    if (n != 128)
      begin errors++; $display("FAIL save_busy_len: got %0d expected 128", n); end
    checks++;
    if (page_diff(0) != 0)
      begin errors++; $display("FAIL save_contents: got %0d bad entries expected 0", page_diff(0)); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < NUM_PAGES; i++) begin
      exp_tags.push_back(TAG_W'(i));
      drive_alloc(g, t, n);
      e = exp_tags.pop_front();
      checks++;
      if ({g, t} !== {1'b1, e})
        begin errors++; $display("FAIL fill_tag: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    end
    checks++;
    if (bus.ckpt_full !== 1'b1)
      begin errors++; $display("FAIL fill_full: got %b expected 1", bus.ckpt_full); end
    drive_alloc(g, t, n);
    checks++;
    if (g !== 1'b0)
      begin errors++; $display("FAIL fill_ninth: got gnt=%b expected 0", g); end
    checks++;
    if (bus.busy !== 1'b0)
      begin errors++; $display("FAIL fill_no_save: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      randomize_live();
      take_snap(i);
      exp_tags.push_back(TAG_W'(i));
      drive_alloc(g, t, n);
      e = exp_tags.pop_front();
      checks++;
      if ({g, t} !== {1'b1, e})
        begin errors++; $display("FAIL mp_alloc: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    end
    randomize_live();
    @(negedge clk);
    bus.resolve_valid = 1'b1;
    bus.resolve_mispr = 1'b1;
    bus.resolve_tag   = TAG_W'(1);
    #1;
    checks++;
    if (bus.resolve_ready !== 1'b1)
      begin errors++; $display("FAIL mp_ready: got %b expected 1", bus.resolve_ready); end
    @(negedge clk);
    clear_inputs();
    wait_restore_done(nwe, n);
    checks++;
    if (bus.restore_done !== 1'b1)
      begin errors++; $display("FAIL mp_done: got %b expected 1 (timeout)", bus.restore_done); end
    checks++;
    if (nwe != 128)
      begin errors++; $display("FAIL mp_we_cycles: got %0d expected 128", nwe); end
    @(negedge clk);
    checks++;
    if ({bus.restore_done, bus.busy} !== 2'b00)
      begin errors++; $display("FAIL mp_done_pulse: got %b expected 00", {bus.restore_done, bus.busy}); end
    checks++;
    if (live_diff(1) != 0)
      begin errors++; $display("FAIL mp_live_restored: got %0d bad entries expected 0", live_diff(1)); end
    exp_tags.push_back(TAG_W'(1));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t} !== {1'b1, e})
      begin errors++; $display("FAIL mp_next_tag: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
  endtask

  task automatic test_resolve_order();
    do_reset();
    for (int i = 0; i < NUM_PAGES; i++) begin
      exp_tags.push_back(TAG_W'(i));
      drive_alloc(g, t, n);
      e = exp_tags.pop_front();
      checks++;
      if ({g, t} !== {1'b1, e})
        begin errors++; $display("FAIL ro_alloc: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    end
    @(negedge clk);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = TAG_W'(2);
    @(negedge clk);
    bus.resolve_tag   = TAG_W'(0);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bus.ckpt_full !== 1'b1)
      begin errors++; $display("FAIL ro_not_early: got full=%b expected 1", bus.ckpt_full); end
    @(negedge clk);
    checks++;
    if (bus.ckpt_full !== 1'b0)
      begin errors++; $display("FAIL ro_head_retired: got full=%b expected 0", bus.ckpt_full); end
    exp_tags.push_back(TAG_W'(0));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t} !== {1'b1, e})
      begin errors++; $display("FAIL ro_realloc: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    checks++;
    if (bus.ckpt_full !== 1'b1)
      begin errors++; $display("FAIL ro_page2_held: got full=%b expected 1", bus.ckpt_full); end
    @(negedge clk);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = TAG_W'(1);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 2; i++) begin
      exp_tags.push_back(TAG_W'(i));
      drive_alloc(g, t, n);
      e = exp_tags.pop_front();
      checks++;
      if ({g, t} !== {1'b1, e})
        begin errors++; $display("FAIL ro_freed: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
    end
    drive_alloc(g, t, n);
    checks++;
    if (g !== 1'b0)
      begin errors++; $display("FAIL ro_full_again: got gnt=%b expected 0", g); end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      randomize_live();
      take_snap(i);
      drive_alloc(g, t, n);
    end
    randomize_live();
    @(negedge clk);
    bus.alloc_req     = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.resolve_mispr = 1'b1;
    bus.resolve_tag   = TAG_W'(0);
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b0)
      begin errors++; $display("FAIL col_no_grant: got %b expected 0", bus.alloc_gnt); end
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({bus.busy, bus.arr_we} !== 2'b11)
      begin errors++; $display("FAIL col_restore_run: got %b expected 11", {bus.busy, bus.arr_we}); end
    wait_restore_done(nwe, n);
    @(negedge clk);
    checks++;
    if (live_diff(0) != 0)
      begin errors++; $display("FAIL col_live: got %0d bad entries expected 0", live_diff(0)); end
    exp_tags.push_back(TAG_W'(0));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t} !== {1'b1, e})
      begin errors++; $display("FAIL col_next_tag: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
  endtask

  task automatic test_reset_mid_save();
    @(negedge clk);
    bus.alloc_req = 1'b1;
    @(negedge clk);
    bus.alloc_req = 1'b0;
    n = 0;
    while (bus.shd_addr != ADDR_W'(60) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({bus.shd_we, bus.shd_addr} !== {1'b1, ADDR_W'(60)})
      begin errors++; $display("FAIL rms_reach60: got we=%b addr=%0d expected we=1 addr=60", bus.shd_we, bus.shd_addr); end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.shd_we, bus.arr_we, bus.ckpt_full, bus.shd_addr, bus.arr_addr, bus.shd_page} !== 0)
      begin errors++; $display("FAIL rms_outputs: got %h expected 0",
        {bus.busy, bus.shd_we, bus.arr_we, bus.ckpt_full, bus.shd_addr, bus.arr_addr, bus.shd_page}); end
    checks++;
    if (bus.resolve_ready !== 1'b1)
      begin errors++; $display("FAIL rms_ready: got %b expected 1", bus.resolve_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_tags.push_back(TAG_W'(0));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t, n} !== {1'b1, e, 32'd128})
      begin errors++; $display("FAIL rms_fresh: got gnt=%b tag=%0d len=%0d expected gnt=1 tag=%0d len=128", g, t, n, e); end
  endtask

  task automatic test_invalid_tag();
    do_reset();
    drive_alloc(g, t, n);
    @(negedge clk);
    bus.resolve_valid = 1'b1;
    bus.resolve_mispr = 1'b1;
    bus.resolve_tag   = TAG_W'(5);
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({bus.busy, bus.arr_we} !== 2'b00)
      begin errors++; $display("FAIL inv_ignored: got %b expected 00", {bus.busy, bus.arr_we}); end
`ifdef CHUCHU_CKPT_ERR_EN
    checks++;
    if (bus.ckpt_err !== 1'b1)
      begin errors++; $display("FAIL inv_err_set: got %b expected 1", bus.ckpt_err); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ckpt_err !== 1'b1)
      begin errors++; $display("FAIL inv_err_sticky: got %b expected 1", bus.ckpt_err); end
`endif
    exp_tags.push_back(TAG_W'(1));
    drive_alloc(g, t, n);
    e = exp_tags.pop_front();
    checks++;
    if ({g, t} !== {1'b1, e})
      begin errors++; $display("FAIL inv_next_tag: got gnt=%b tag=%0d expected gnt=1 tag=%0d", g, t, e); end
  endtask

  initial begin
    for (int p = 0; p < NUM_PAGES; p++)
      for (int i = 0; i < DEPTH; i++) shd[p][i] = DATA_W'($urandom);
    randomize_live();
    test_reset();
    test_single_save();
    test_fill();
    test_mispredict();
    test_resolve_order();
    test_collision();
    test_reset_mid_save();
    test_invalid_tag();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
